// File: rtl/reg_file_mp.sv
// Two-read / two-write register file with hardwired-zero r0 and a sweep-clear engine.
// Latency: combinational reads (READ_LATENCY=0) or one edge gated by i_reg_read (READ_LATENCY=1).
// Backpressure: none; writes and clear requests arriving during a sweep are dropped.
module reg_file_mp #(
  parameter int NUM_REGS     = 12,
  parameter int REG_WIDTH    = 8,
  parameter int SPEC_REG     = 11,
  parameter int READ_LATENCY = 0,
  parameter int BYPASS       = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_reg_read,
  input  logic                        i_reg_write,
  input  logic [$clog2(NUM_REGS)-1:0] i_rd_addr,
  input  logic [REG_WIDTH-1:0]        i_rd_in,
  input  logic                        i_car_write,
  input  logic [REG_WIDTH-1:0]        i_car_in,
  input  logic [$clog2(NUM_REGS)-1:0] i_rt_addr,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs_addr,
  output logic [REG_WIDTH-1:0]        o_rt_out,
  output logic [REG_WIDTH-1:0]        o_rs_out,
  input  logic                        i_clr_req,
  output logic                        o_clr_busy
);

  localparam int              AW       = $clog2(NUM_REGS);
  localparam logic [AW:0]     LP_NREGS = (AW+1)'(NUM_REGS);
  localparam logic [AW-1:0]   LP_SPEC  = AW'(SPEC_REG);
  localparam logic [AW-1:0]   LP_LAST  = AW'(NUM_REGS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [AW-1:0]          r_idx;
  logic [AW-1:0]          w_idx_nxt;
  logic [REG_WIDTH-1:0]   r_regs [NUM_REGS];

  logic                   w_idle;
  logic                   w_gen_we;
  logic                   w_car_we;
  logic [REG_WIDTH-1:0]   w_rt_val;
  logic [REG_WIDTH-1:0]   w_rs_val;

  // Writes are only honoured in IDLE; r0 and out-of-range targets are silently dropped.
  assign w_idle   = (r_state == S_IDLE);
  assign w_gen_we = w_idle && i_reg_write && (i_rd_addr != '0) && ({1'b0, i_rd_addr} < LP_NREGS);
  assign w_car_we = w_idle && i_car_write;

  assign o_clr_busy = (r_state == S_SWEEP);

  // Read value for one port: zero for r0/out-of-range, then carry bypass, then general bypass, then storage.
  function automatic logic [REG_WIDTH-1:0] f_read(input logic [AW-1:0] a);
    logic [REG_WIDTH-1:0] v;
    v = '0;
    if ((a != '0) && ({1'b0, a} < LP_NREGS)) begin
      if ((BYPASS != 0) && w_car_we && (a == LP_SPEC)) begin
        v = i_car_in;
      end else if ((BYPASS != 0) && w_gen_we && (a == i_rd_addr)) begin
        v = i_rd_in;
      end else begin
        v = r_regs[a];
      end
    end
    return v;
  endfunction

  // Resolve both read ports from current storage and any same-cycle write.
  always_comb begin
    w_rt_val = f_read(i_rt_addr);
    w_rs_val = f_read(i_rs_addr);
  end

  // Storage update: reset clears all, sweep zeroes one entry per edge, otherwise carry write lands last so it wins.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == S_SWEEP) begin
      r_regs[r_idx] <= '0;
    end else begin
      if (w_gen_we) begin
        r_regs[i_rd_addr] <= i_rd_in;
      end
      if (w_car_we) begin
        r_regs[LP_SPEC] <= i_car_in;
      end
    end
  end

  // Sweep FSM state and index registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Sweep FSM next state: start at index 1 (r0 is never stored), finish after the last index.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = S_SWEEP;
          w_idx_nxt   = AW'(1);
        end
      end
      S_SWEEP: begin
        if (r_idx == LP_LAST) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      logic w_unused_reg_read;
      assign w_unused_reg_read = i_reg_read;
      assign o_rt_out = w_rt_val;
      assign o_rs_out = w_rs_val;
    end else begin : g_reg_read
      logic [REG_WIDTH-1:0] r_rt_out;
      logic [REG_WIDTH-1:0] r_rs_out;
      // Output registers load the resolved read value only when i_reg_read is set.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_rt_out <= '0;
          r_rs_out <= '0;
        end else if (i_reg_read) begin
          r_rt_out <= w_rt_val;
          r_rs_out <= w_rs_val;
        end
      end
      assign o_rt_out = r_rt_out;
      assign o_rs_out = r_rs_out;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a combinational/bypass instance and a registered/no-bypass instance share stimulus.
// Expected values come from an array model of the register file plus sweep progress.
// Inputs change 1 time unit after posedge; outputs are sampled before the next edge.
module tb_reg_file_mp;

  logic       clk = 1'b0;
  logic       reset, reg_read, reg_write, car_write, clr_req;
  logic [3:0] rd_addr, rt_addr, rs_addr;
  logic [7:0] rd_in, car_in;
  logic [7:0] rt0, rs0, rt1, rs1;
  logic       busy0, busy1;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state.
  logic [7:0] mem [12];
  bit         m_busy;
  int         m_pos;
  logic [7:0] q_rt, q_rs;

  always #5 clk = ~clk;

  reg_file_mp dut0 (
    .i_clk(clk), .i_reset(reset), .i_reg_read(reg_read), .i_reg_write(reg_write),
    .i_rd_addr(rd_addr), .i_rd_in(rd_in), .i_car_write(car_write), .i_car_in(car_in),
    .i_rt_addr(rt_addr), .i_rs_addr(rs_addr), .o_rt_out(rt0), .o_rs_out(rs0),
    .i_clr_req(clr_req), .o_clr_busy(busy0)
  );

  reg_file_mp #(.READ_LATENCY(1), .BYPASS(0)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_reg_read(reg_read), .i_reg_write(reg_write),
    .i_rd_addr(rd_addr), .i_rd_in(rd_in), .i_car_write(car_write), .i_car_in(car_in),
    .i_rt_addr(rt_addr), .i_rs_addr(rs_addr), .o_rt_out(rt1), .o_rs_out(rs1),
    .i_clr_req(clr_req), .o_clr_busy(busy1)
  );

  function automatic logic [7:0] exp_read(input logic [3:0] a, input bit byp);
    if (a == 0 || a >= 12) return 8'h00;
    if (byp && !m_busy) begin
      if (car_write && a == 11) return car_in;
      if (reg_write && a == rd_addr) return rd_in;
    end
    return mem[a];
  endfunction

  // Advance the model by one edge using the inputs currently applied, then let the DUT take the edge.
  task automatic tick();
    if (reset) begin
      foreach (mem[i]) mem[i] = 8'h00;
      m_busy = 0; m_pos = 0; q_rt = 8'h00; q_rs = 8'h00;
    end else begin
      if (reg_read) begin
        q_rt = exp_read(rt_addr, 0);
        q_rs = exp_read(rs_addr, 0);
      end
      if (m_busy) begin
        mem[m_pos] = 8'h00;
        if (m_pos == 11) begin m_busy = 0; m_pos = 0; end
        else m_pos++;
      end else begin
        if (reg_write && rd_addr != 0 && rd_addr < 12) mem[rd_addr] = rd_in;
        if (car_write) mem[11] = car_in;
        if (clr_req) begin m_busy = 1; m_pos = 1; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reg_read = 0; reg_write = 0; car_write = 0; clr_req = 0;
    rd_addr = 0; rd_in = 0; car_in = 0;
  endtask

  task automatic test_reset();
    reset = 1; quiet(); rt_addr = 1; rs_addr = 11;
    tick(); tick();
    reset = 0; #1;
    n_checks++; if (busy0 !== 1'b0) begin n_fails++; $display("FAIL reset_busy0 got %b exp 0", busy0); end
    n_checks++; if (busy1 !== 1'b0) begin n_fails++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    n_checks++; if ({rt0, rs0} !== 16'h0) begin n_fails++; $display("FAIL reset_comb_out got %h/%h exp 00/00", rt0, rs0); end
    n_checks++; if ({rt1, rs1} !== 16'h0) begin n_fails++; $display("FAIL reset_reg_out got %h/%h exp 00/00", rt1, rs1); end
  endtask

  task automatic test_write_read();
    logic [7:0] e_rt, e_rs;
    for (int i = 1; i < 12; i++) begin
      reg_write = 1; rd_addr = 4'(i); rd_in = 8'(8'h10 + i); tick();
    end
    reg_write = 1; rd_addr = 0; rd_in = 8'hFF; tick();
    reg_write = 0;
    for (int a = 0; a < 12; a++) begin
      rt_addr = 4'(a); rs_addr = 4'((a + 5) % 12); reg_read = 1; #1;
      e_rt = (a == 0) ? 8'h00 : 8'(8'h10 + a);
      e_rs = (((a + 5) % 12) == 0) ? 8'h00 : 8'(8'h10 + ((a + 5) % 12));
      n_checks++; if (rt0 !== e_rt) begin n_fails++; $display("FAIL wr_rt0 a=%0d got %h exp %h", a, rt0, e_rt); end
      n_checks++; if (rs0 !== e_rs) begin n_fails++; $display("FAIL wr_rs0 a=%0d got %h exp %h", (a + 5) % 12, rs0, e_rs); end
      tick();
      n_checks++; if (rt1 !== e_rt) begin n_fails++; $display("FAIL wr_rt1 a=%0d got %h exp %h", a, rt1, e_rt); end
      n_checks++; if (rs1 !== e_rs) begin n_fails++; $display("FAIL wr_rs1 a=%0d got %h exp %h", (a + 5) % 12, rs1, e_rs); end
    end
    reg_read = 0;
  endtask

  task automatic test_collision();
    reg_write = 1; rd_addr = 11; rd_in = 8'hAA; car_write = 1; car_in = 8'h55;
    rt_addr = 11; rs_addr = 11; reg_read = 1; #1;
    n_checks++; if (rt0 !== 8'h55) begin n_fails++; $display("FAIL coll_bypass got %h exp 55", rt0); end
    tick();
    n_checks++; if (rt1 !== 8'h1B) begin n_fails++; $display("FAIL coll_nobypass got %h exp 1b", rt1); end
    quiet(); reg_read = 1; #1;
    n_checks++; if (rt0 !== 8'h55) begin n_fails++; $display("FAIL coll_stored0 got %h exp 55", rt0); end
    tick();
    n_checks++; if (rs1 !== 8'h55) begin n_fails++; $display("FAIL coll_stored1 got %h exp 55", rs1); end
    reg_read = 0;
  endtask

  task automatic test_read_hold();
    reg_write = 1; rd_addr = 3; rd_in = 8'h3C; rt_addr = 3; reg_read = 0; tick();
    reg_write = 0; tick();
    n_checks++; if (rt1 !== 8'h55) begin n_fails++; $display("FAIL hold_rt1 got %h exp 55", rt1); end
    reg_read = 1; tick(); reg_read = 0;
    n_checks++; if (rt1 !== 8'h3C) begin n_fails++; $display("FAIL load_rt1 got %h exp 3c", rt1); end
    rt_addr = 1; tick();
    n_checks++; if (rt1 !== 8'h3C) begin n_fails++; $display("FAIL hold2_rt1 got %h exp 3c", rt1); end
  endtask

  task automatic test_random();
    logic [7:0] e_rt, e_rs;
    for (int c = 0; c < 300; c++) begin
      reg_write = 1'($urandom_range(0, 1)); rd_addr = 4'($urandom_range(0, 15)); rd_in = 8'($urandom);
      car_write = ($urandom_range(0, 3) == 0); car_in = 8'($urandom);
      rt_addr = 4'($urandom_range(0, 15)); rs_addr = 4'($urandom_range(0, 15));
      reg_read = 1'($urandom_range(0, 1)); #1;
      e_rt = exp_read(rt_addr, 1); e_rs = exp_read(rs_addr, 1);
      n_checks++; if (rt0 !== e_rt) begin n_fails++; $display("FAIL rnd_rt0 c=%0d got %h exp %h", c, rt0, e_rt); end
      n_checks++; if (rs0 !== e_rs) begin n_fails++; $display("FAIL rnd_rs0 c=%0d got %h exp %h", c, rs0, e_rs); end
      tick();
      n_checks++; if (rt1 !== q_rt) begin n_fails++; $display("FAIL rnd_rt1 c=%0d got %h exp %h", c, rt1, q_rt); end
      n_checks++; if (rs1 !== q_rs) begin n_fails++; $display("FAIL rnd_rs1 c=%0d got %h exp %h", c, rs1, q_rs); end
    end
    quiet();
  endtask

  task automatic test_out_of_range();
    reg_write = 1; rd_addr = 14; rd_in = 8'hEE; rt_addr = 14; rs_addr = 15; reg_read = 1; #1;
    n_checks++; if ({rt0, rs0} !== 16'h0) begin n_fails++; $display("FAIL oor_read0 got %h/%h exp 00/00", rt0, rs0); end
    tick(); quiet();
    n_checks++; if ({rt1, rs1} !== 16'h0) begin n_fails++; $display("FAIL oor_read1 got %h/%h exp 00/00", rt1, rs1); end
    for (int a = 1; a < 12; a++) begin
      rt_addr = 4'(a); #1;
      n_checks++; if (rt0 !== mem[a]) begin n_fails++; $display("FAIL oor_unchanged a=%0d got %h exp %h", a, rt0, mem[a]); end
    end
  endtask

  task automatic test_sweep();
    int cnt = 0;
    logic [7:0] e_rt, e_rs;
    for (int i = 1; i < 12; i++) begin
      reg_write = 1; rd_addr = 4'(i); rd_in = 8'($urandom_range(1, 255)); tick();
    end
    quiet(); clr_req = 1; tick(); clr_req = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy0 !== 1'b1) break;
      cnt++;
      if (c == 4) begin
        reg_write = 1; rd_addr = 5; rd_in = 8'h77; car_write = 1; car_in = 8'h66; clr_req = 1;
      end else begin
        reg_write = 0; car_write = 0; clr_req = 0;
      end
      rt_addr = 4'($urandom_range(0, 11)); rs_addr = 5; reg_read = 1; #1;
      e_rt = exp_read(rt_addr, 1); e_rs = exp_read(rs_addr, 1);
      n_checks++; if (rt0 !== e_rt) begin n_fails++; $display("FAIL sweep_rt0 c=%0d got %h exp %h", c, rt0, e_rt); end
      n_checks++; if (rs0 !== e_rs) begin n_fails++; $display("FAIL sweep_rs0 c=%0d got %h exp %h", c, rs0, e_rs); end
      tick();
      n_checks++; if (rt1 !== q_rt) begin n_fails++; $display("FAIL sweep_rt1 c=%0d got %h exp %h", c, rt1, q_rt); end
    end
    quiet();
    n_checks++; if (cnt != 11) begin n_fails++; $display("FAIL sweep_busy_len got %0d exp 11", cnt); end
    n_checks++; if (busy1 !== 1'b0) begin n_fails++; $display("FAIL sweep_busy1_end got %b exp 0", busy1); end
    for (int a = 0; a < 12; a++) begin
      rt_addr = 4'(a); #1;
      n_checks++; if (rt0 !== 8'h00) begin n_fails++; $display("FAIL sweep_cleared a=%0d got %h exp 00", a, rt0); end
    end
    reg_write = 1; rd_addr = 5; rd_in = 8'h99; tick(); quiet();
    rt_addr = 5; #1;
    n_checks++; if (rt0 !== 8'h99) begin n_fails++; $display("FAIL sweep_post_write got %h exp 99", rt0); end
  endtask

  task automatic test_sweep_reset();
    int waited = 0;
    for (int i = 1; i < 12; i++) begin
      reg_write = 1; rd_addr = 4'(i); rd_in = 8'(8'hA0 + i); tick();
    end
    quiet(); clr_req = 1; tick(); clr_req = 0;
    tick(); tick(); tick();
    reset = 1; tick(); reset = 0; #1;
    n_checks++; if (busy0 !== 1'b0) begin n_fails++; $display("FAIL abort_busy got %b exp 0", busy0); end
    for (int a = 1; a < 12; a++) begin
      rt_addr = 4'(a); #1;
      n_checks++; if (rt0 !== 8'h00) begin n_fails++; $display("FAIL abort_zero a=%0d got %h exp 00", a, rt0); end
    end
    clr_req = 1; tick(); clr_req = 0;
    n_checks++; if (busy0 !== 1'b1) begin n_fails++; $display("FAIL abort_restart got %b exp 1", busy0); end
    while (busy0 === 1'b1 && waited < 20) begin tick(); waited++; end
    n_checks++; if (busy0 !== 1'b0 || waited != 11) begin
      n_fails++; $display("FAIL abort_second_sweep busy=%b cycles=%0d exp 0/11", busy0, waited);
    end
  endtask

  initial begin
    reset = 1; quiet(); rt_addr = 0; rs_addr = 0;
    test_reset();
    test_write_read();
    test_collision();
    test_read_hold();
    test_random();
    test_out_of_range();
    test_sweep();
    test_sweep_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised register file for the datapath: two read ports, one general write port, and a dedicated carry/special-register write port. It extends the original register file with:
- hardwired-zero register 0
- selectable combinational or registered reads
- optional write-to-read bypass
- defined write-collision priority
- a sequential sweep-clear engine that zeroes the file without a full reset

It sits between decode (addresses) and the ALU/writeback stage (operands, results, carry).

## Interface
Parameters:
- NUM_REGS, 12, number of registers; index 0 is hardwired zero. Range 2..256.
- REG_WIDTH, 8, bits per register.
- SPEC_REG, 11, index written by the carry port. Must satisfy 1 ≤ SPEC_REG < NUM_REGS.
- READ_LATENCY, 0, 0 = combinational read; 1 = registered read gated by reg_read.
- BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read ports return stored contents.

Ports (AW = $clog2(NUM_REGS)):
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- reg_read  in  1  read-register load enable. Used only when READ_LATENCY=1.
- reg_write  in  1  general write enable.
- rd_addr  in  AW  general write address.
- rd_in  in  REG_WIDTH  general write data.
- car_write  in  1  special-register write enable.
- car_in  in  REG_WIDTH  special-register write data.
- rt_addr, rs_addr  in  AW  read addresses.
- rt_out, rs_out  out  REG_WIDTH  read data.
- clr_req  in  1  single-cycle request to start a sweep clear.
- clr_busy  out  1  high while a sweep clear is in progress.

## Operation
- Register 0 always reads 0. Writes to register 0 are dropped.
- Addresses ≥ NUM_REGS: writes are dropped and reads return 0.
- Write resolution at each edge, in IDLE state only:
  - car_write writes regs[SPEC_REG] ← car_in.
  - reg_write writes regs[rd_addr] ← rd_in.
  - If both are asserted and rd_addr == SPEC_REG, car_in wins.
- Read value:
  - With BYPASS=1, if the read address equals an address being written this cycle, the read returns the winning write data.
  - Otherwise the read returns the stored contents.
  - Register 0 and out-of-range addresses return 0 regardless of bypass.
- READ_LATENCY=0: rt_out/rs_out are combinational from the read value.
- READ_LATENCY=1: on a posedge with reg_read=1, rt_out/rs_out load the read value. They hold while reg_read=0.
- Sweep-clear FSM, states IDLE and SWEEP, with index counter idx (AW bits):
  - IDLE→SWEEP: on an edge with clr_req=1. idx ← 1, clr_busy ← 1. Writes presented on that same edge still take effect.
  - In SWEEP, each edge: regs[idx] ← 0, then idx ← idx+1.
  - SWEEP→IDLE: on the edge that clears index NUM_REGS-1. clr_busy ← 0.
  - In SWEEP, reg_write and car_write are ignored (dropped, not queued).
  - In SWEEP, clr_req is ignored.
  - In SWEEP, reads remain valid: cleared entries read 0, uncleared entries read their old value.
  - In SWEEP, bypass is inactive.
- Reset (highest priority):
  - Every register, rt_out/rs_out (READ_LATENCY=1), idx and clr_busy go to 0.
  - State goes to IDLE.
  - Reset during SWEEP aborts the sweep.

## Timing
- Write latency: data presented before edge N is stored at edge N.
  - BYPASS=0: readable combinationally after edge N.
  - BYPASS=1: visible on the read ports before edge N.
- Registered read (READ_LATENCY=1): address/reg_read sampled at edge N, data valid after edge N.
- clr_req at edge k:
  - clr_busy is high after edges k … k+NUM_REGS-2, i.e. for NUM_REGS-1 cycles (11 with defaults).
  - clr_busy falls after edge k+NUM_REGS-1.
  - Writes are accepted again at edge k+NUM_REGS-1+1.
- Reset values: rt_out = rs_out = 0 (registered mode); clr_busy = 0. In combinational mode the outputs read 0 because all registers are 0.

## Test plan
- Reset, then write regs 1..11 with 8'h10+i; read each on rt and rs → returns 8'h10+i. Read reg 0 → 0 after an attempted write of 8'hFF to reg 0.
- Same edge: reg_write rd_addr=11 rd_in=8'hAA and car_write car_in=8'h55 → reg 11 = 8'h55. With BYPASS=1, rt_addr=11 reads 8'h55 in that cycle; with BYPASS=0 it reads the old value.
- READ_LATENCY=1: write reg 3 = 8'h3C, then read with reg_read=0 → rt_out holds its previous value. Pulse reg_read → rt_out = 8'h3C one edge later.
- Fill all registers with nonzero values, then pulse clr_req:
  - clr_busy high for exactly 11 cycles.
  - A reg_write of 8'h77 to reg 5 mid-sweep is dropped.
  - Afterwards all registers read 0 and a new write succeeds.
- Assert reset at sweep cycle 4 → clr_busy = 0 next cycle, all registers 0, FSM accepts a new clr_req.
- Out-of-range: NUM_REGS=12, write rd_addr=14 → no register changes; reading address 14 → 0.
